truth_table_sweep: RTL
======================

# truth_table_sweep

Programmable multi-channel truth-table evaluator with a built-in exhaustive input sweeper. It holds up to N_CH boolean functions of N_IN inputs as loadable truth tables. On `start` it steps through all 2^N_IN input combinations in ascending binary order. Each combination is emitted as a row over a valid/ready stream, and the minterm count of each channel is accumulated. It is the sequential, parametrised replacement for hand-written per-function test sweeps in the logic-guide benches.

## Interface
- `N_IN`, default 3: number of function inputs; legal range 1..6.
- `N_CH`, default 5: number of function channels; legal range 1..8.
- Derived `CHW = max(1, $clog2(N_CH))` and `CNTW = N_IN+1`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_we`  in  1  truth-table write strobe.
- `cfg_ch`  in  CHW  channel selected for the write.
- `cfg_tt`  in  2^N_IN  truth table; bit i is the output for input vector i.
- `start`  in  1  single-cycle sweep request.
- `busy`  out  1  high while a sweep is in progress (RUN state).
- `row_valid`  out  1  current row is presented.
- `row_ready`  in  1  consumer accepts the row.
- `row_x`  out  N_IN  input vector; MSB is the first variable.
- `row_s`  out  N_CH  channel outputs for `row_x`; bit c is channel c.
- `done`  out  1  one-cycle pulse after the last row is accepted.
- `ones`  out  N_CH*CNTW  per-channel count of 1-rows; channel c occupies slice [c*CNTW +: CNTW].

## Operation
- FSM states IDLE, RUN, DONE.
- **Reset.** On `rst_n`=0 at a clock edge:
  - state goes to IDLE;
  - all tables, `row_x` and `ones` clear to 0;
  - `busy`, `row_valid` and `done` go to 0.
  - This applies mid-sweep as well: the sweep is abandoned with no `done` pulse.
- **IDLE.**
  - `cfg_we`=1 writes `cfg_tt` into the table of `cfg_ch`. A `cfg_ch` ≥ N_CH is ignored.
  - `start`=1 moves to RUN, sets `row_x`=0 and clears all `ones` counters.
  - If `start` and `cfg_we` are both high, the write is taken first. The sweep then uses the new table.
- **RUN.**
  - `row_valid`=1 and `busy`=1.
  - `row_s[c]` = table[c][`row_x`], decoded from the registered `row_x`.
  - On a handshake (`row_valid`&`row_ready`), every `ones[c]` increments by `row_s[c]`.
    - If `row_x` = 2^N_IN−1, go to DONE.
    - Otherwise `row_x` increments by 1.
  - While `row_ready`=0, `row_x` and `row_s` hold stable.
  - `cfg_we` and `start` are ignored in RUN; tables are frozen during a sweep.
- **DONE.**
  - `done`=1 for exactly one cycle, `row_valid`=0, `busy`=0, `start` ignored.
  - The state then returns to IDLE.
- `ones` holds its final value until the next accepted `start` or reset.
- Counter width: `ones[c]` reaches at most 2^N_IN, which fits in CNTW bits with no saturation.
- `row_x` increments cannot wrap inside a sweep, because the terminal row exits RUN.

## Timing
- With `start` sampled high at edge t, the first row (`row_x`=0) is valid after t.
- With `row_ready` held at 1, rows 0..2^N_IN−1 occupy consecutive cycles, one row per cycle. The `done` pulse follows in the next cycle, after 2^N_IN+1 cycles of latency.
- Each cycle of `row_ready`=0 adds one cycle of latency.
- `row_s` is combinational from registered state and the table only. There is no combinational path from `row_ready` to `row_valid`.
- `ones` is final in the same cycle `done` is high.
- A table write at edge t is visible in the table from cycle t+1.

## Structure
- Package `truth_table_pkg` holds:
  - the state enum `tts_state_t` {IDLE, RUN, DONE};
  - the limits `N_IN_MAX`=6 and `N_CH_MAX`=8;
  - a function `cnt_w(n_in)`.
- Sub-module `tt_lut`: N_CH × 2^N_IN register array with write port (`cfg_we`, `cfg_ch`, `cfg_tt`), an enable that blocks writes outside IDLE, and read mux (`row_x` → `row_s`).
- The top level contains the FSM, the `row_x` counter and the `ones` accumulators.

## Test plan
- **Single-channel sweep.** Defaults. Load ch0 = 8'b0111_0000, start, `row_ready`=1.
  - Rows x=0..7 appear with `row_s[0]` = 0,0,0,0,1,1,1,0.
  - `done` arrives at the 9th cycle after start, with `ones[0]`=3.
- **Multi-channel loads.** Load ch1 = 8'b0000_0010, ch2 = 8'b0100_0101, ch3 = 8'b0101_0100, ch4 = 8'b1011_1100, then sweep.
  - Final counts: ones[1]=1, ones[2]=3, ones[3]=3, ones[4]=5.
- **Backpressure.** Hold `row_ready`=0 for 3 cycles at x=5.
  - `row_x`=5 and `row_s` stay stable across those cycles.
  - No count is taken twice.
  - `done` arrives 3 cycles later than in the first scenario.
- **Ignored inputs in RUN.** During RUN, pulse `start` and `cfg_we` (ch0 = 8'hFF).
  - The sweep is unaffected and `ones[0]`=3.
  - A second sweep also gives `ones[0]`=3.
- **Reset mid-sweep.** Drop `rst_n` at x=4.
  - Next cycle: IDLE, `row_valid`=0, `busy`=0, `ones`=0, all tables 0, and no `done`.
  - A fresh sweep then gives all counts 0.
- **Parameter corners.** N_IN=1, N_CH=1 with tt=2'b10: 2 rows, ones=1. N_IN=6, N_CH=8 with ch7 = all 1s: 64 rows, ones[7]=64.

Source files
------------

// File: rtl/truth_table_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package truth_table_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tts_state_t;

    localparam int N_IN_MAX = 6;
    localparam int N_CH_MAX = 8;

    // One extra bit so a channel that is 1 on every row (2^n_in) still fits.
    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// Config port plus row stream and results of the truth-table sweeper.
interface truth_table_sweep_if #(
    parameter int N_IN = 3,
    parameter int N_CH = 5
);
    localparam int CHW  = truth_table_pkg::ch_w(N_CH);
    localparam int CNTW = truth_table_pkg::cnt_w(N_IN);
    localparam int TTW  = 1 << N_IN;

    logic                 cfg_we;
    logic [CHW-1:0]       cfg_ch;
    logic [TTW-1:0]       cfg_tt;
    logic                 start;
    logic                 busy;
    logic                 row_valid;
    logic                 row_ready;
    logic [N_IN-1:0]      row_x;
    logic [N_CH-1:0]      row_s;
    logic                 done;
    logic [N_CH*CNTW-1:0] ones;

    modport master (
        output cfg_we, cfg_ch, cfg_tt, start, row_ready,
        input  busy, row_valid, row_x, row_s, done, ones
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_tt, start, row_ready,
        output busy, row_valid, row_x, row_s, done, ones
    );

endinterface

// File: rtl/truth_table_sweep_lut.sv
// Per-channel truth-table storage with a gated write port and a row read mux.
module tt_lut
    import truth_table_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int N_CH = 5,
    parameter int CHW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic                   i_we,
    input  logic [CHW-1:0]         i_ch,
    input  logic [(1<<N_IN)-1:0]   i_tt,
    input  logic [N_IN-1:0]        i_x,
    output logic [N_CH-1:0]        o_s
);
    localparam int TTW = 1 << N_IN;

    logic [N_CH-1:0][TTW-1:0] r_tt;

    // Channel compare per entry: selects >= N_CH match nothing and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tt <= '0;
        end else if (i_en && i_we) begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_ch == CHW'(c)) r_tt[c] <= i_tt;
            end
        end
    end

    always_comb begin
        o_s = '0;
        for (int c = 0; c < N_CH; c++) o_s[c] = r_tt[c][i_x];
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Exhaustive sweeper: streams every input vector with all channel outputs and counts minterms.
module truth_table_sweep
    import truth_table_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int N_CH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    truth_table_sweep_if.slave bus
);
    localparam int CHW  = ch_w(N_CH);
    localparam int CNTW = cnt_w(N_IN);

    tts_state_t                r_state;
    logic [N_IN-1:0]           r_x;
    logic [N_CH-1:0][CNTW-1:0] r_ones;
    logic                      r_busy;
    logic                      r_valid;
    logic                      r_done;
    logic [N_CH-1:0]           w_s;
    logic                      w_hs;
    logic                      w_last;
    logic                      w_cfg_en;

    // Tables are frozen outside IDLE; a write with start lands before the first row is read.
    assign w_cfg_en = (r_state == IDLE);
    assign w_hs     = r_valid && bus.row_ready;
    assign w_last   = (r_x == {N_IN{1'b1}});

    tt_lut #(.N_IN(N_IN), .N_CH(N_CH), .CHW(CHW)) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cfg_en),
        .i_we  (bus.cfg_we),
        .i_ch  (bus.cfg_ch),
        .i_tt  (bus.cfg_tt),
        .i_x   (r_x),
        .o_s   (w_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= RUN;
                        r_x     <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        for (int c = 0; c < N_CH; c++) r_ones[c] <= r_ones[c] + CNTW'(w_s[c]);
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.row_valid = r_valid;
    assign bus.row_x     = r_x;
    assign bus.row_s     = w_s;
    assign bus.done      = r_done;
    assign bus.ones      = r_ones;

endmodule
